// File: rtl/jt51_slot_regbank.sv
// YM2151-style parameter register bank and 32-slot sequencer. Each parameter is
// read with a slot index shifted back by (stage-1), so no delay pipeline is needed.
module jt51_slot_regbank (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       up_dt1,
    input  logic       up_tl,
    input  logic       up_ks,
    input  logic       up_amsen,
    input  logic       up_dt2,
    input  logic       up_d1l,
    input  logic [1:0] op,
    input  logic [2:0] ch,
    input  logic [7:0] op_din,
    input  logic       up_rl,
    input  logic       up_kc,
    input  logic       up_kf,
    input  logic       up_pms,
    input  logic [2:0] ch_sel,
    input  logic [7:0] ch_din,
    input  logic       up_keyon,
    input  logic       csm,
    input  logic       overflow_A,
    output logic [1:0] rl_I,
    output logic [2:0] fb_II,
    output logic [2:0] con_I,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [2:0] pms_I,
    output logic [1:0] ams_VII,
    output logic [2:0] dt1_II,
    output logic [1:0] dt2_I,
    output logic [3:0] mul_VI,
    output logic [6:0] tl_VII,
    output logic [1:0] ks_III,
    output logic [4:0] arate_II,
    output logic       amsen_VII,
    output logic [4:0] rate1_II,
    output logic [4:0] rate2_II,
    output logic [3:0] rrate_II,
    output logic [3:0] d1l_I,
    output logic       keyon_II,
    output logic [4:0] cycles,
    output logic [1:0] cur_op,
    output logic       zero,
    output logic       half,
    output logic       op31_no,
    output logic       op31_acc,
    output logic       m1_enters,
    output logic       m2_enters,
    output logic       c1_enters,
    output logic       c2_enters,
    output logic       use_prevprev1,
    output logic       use_internal_x,
    output logic       use_internal_y,
    output logic       use_prev2,
    output logic       use_prev1
);

    // Channel parameters
    logic [1:0] rl_mem  [8];
    logic [2:0] fb_mem  [8];
    logic [2:0] con_mem [8];
    logic [6:0] kc_mem  [8];
    logic [5:0] kf_mem  [8];
    logic [2:0] pms_mem [8];
    logic [1:0] ams_mem [8];

    // Operator parameters, indexed {op, ch} to match the slot numbering
    logic [2:0] dt1_mem   [32];
    logic [3:0] mul_mem   [32];
    logic [6:0] tl_mem    [32];
    logic [1:0] ks_mem    [32];
    logic [4:0] ar_mem    [32];
    logic       amsen_mem [32];
    logic [4:0] d1r_mem   [32];
    logic [1:0] dt2_mem   [32];
    logic [4:0] d2r_mem   [32];
    logic [3:0] d1l_mem   [32];
    logic [3:0] rr_mem    [32];

    logic [31:0] kon;
    logic [5:0]  csm_cnt;
    logic [4:0]  op_idx;
    logic [4:0]  slot_ii, slot_iii, slot_vi, slot_vii;

    assign op_idx   = {op, ch};
    assign slot_ii  = cycles - 5'd1;
    assign slot_iii = cycles - 5'd2;
    assign slot_vi  = cycles - 5'd5;
    assign slot_vii = cycles - 5'd6;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles   <= '0;
            op31_acc <= 1'b0;
            csm_cnt  <= '0;
        end else if (cen) begin
            cycles   <= cycles + 5'd1;
            op31_acc <= op31_no;
            if (csm && overflow_A)
                csm_cnt <= 6'd32;
            else if (csm_cnt != 6'd0)
                csm_cnt <= csm_cnt - 6'd1;
        end
    end

    // NOTE: these arrays are flops with a defined reset value, so they are cleared
    // in the reset branch; a RAM-mapped table would have to be cleared by the bus instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rl_mem[i]  <= '0;
                fb_mem[i]  <= '0;
                con_mem[i] <= '0;
                kc_mem[i]  <= '0;
                kf_mem[i]  <= '0;
                pms_mem[i] <= '0;
                ams_mem[i] <= '0;
            end
        end else begin
            if (up_rl) begin
                rl_mem[ch_sel]  <= ch_din[7:6];
                fb_mem[ch_sel]  <= ch_din[5:3];
                con_mem[ch_sel] <= ch_din[2:0];
            end
            if (up_kc) kc_mem[ch_sel] <= ch_din[6:0];
            if (up_kf) kf_mem[ch_sel] <= ch_din[7:2];
            if (up_pms) begin
                pms_mem[ch_sel] <= ch_din[6:4];
                ams_mem[ch_sel] <= ch_din[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                dt1_mem[i]   <= '0;
                mul_mem[i]   <= '0;
                tl_mem[i]    <= '0;
                ks_mem[i]    <= '0;
                ar_mem[i]    <= '0;
                amsen_mem[i] <= 1'b0;
                d1r_mem[i]   <= '0;
                dt2_mem[i]   <= '0;
                d2r_mem[i]   <= '0;
                d1l_mem[i]   <= '0;
                rr_mem[i]    <= '0;
            end
        end else begin
            if (up_dt1) begin
                dt1_mem[op_idx] <= op_din[6:4];
                mul_mem[op_idx] <= op_din[3:0];
            end
            if (up_tl) tl_mem[op_idx] <= op_din[6:0];
            if (up_ks) begin
                ks_mem[op_idx] <= op_din[7:6];
                ar_mem[op_idx] <= op_din[4:0];
            end
            if (up_amsen) begin
                amsen_mem[op_idx] <= op_din[7];
                d1r_mem[op_idx]   <= op_din[4:0];
            end
            if (up_dt2) begin
                dt2_mem[op_idx] <= op_din[7:6];
                d2r_mem[op_idx] <= op_din[4:0];
            end
            if (up_d1l) begin
                d1l_mem[op_idx] <= op_din[7:4];
                rr_mem[op_idx]  <= op_din[3:0];
            end
        end
    end

    // Key-on bit order on the bus is M1, C1, M2, C2 - not the slot order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kon <= '0;
        end else if (up_keyon) begin
            kon[{2'd0, op_din[2:0]}] <= op_din[3];
            kon[{2'd1, op_din[2:0]}] <= op_din[5];
            kon[{2'd2, op_din[2:0]}] <= op_din[4];
            kon[{2'd3, op_din[2:0]}] <= op_din[6];
        end
    end

    assign rl_I      = rl_mem[cycles[2:0]];
    assign con_I     = con_mem[cycles[2:0]];
    assign kc_I      = kc_mem[cycles[2:0]];
    assign kf_I      = kf_mem[cycles[2:0]];
    assign pms_I     = pms_mem[cycles[2:0]];
    assign fb_II     = fb_mem[slot_ii[2:0]];
    assign ams_VII   = ams_mem[slot_vii[2:0]];

    assign dt2_I     = dt2_mem[cycles];
    assign d1l_I     = d1l_mem[cycles];
    assign dt1_II    = dt1_mem[slot_ii];
    assign arate_II  = ar_mem[slot_ii];
    assign rate1_II  = d1r_mem[slot_ii];
    assign rate2_II  = d2r_mem[slot_ii];
    assign rrate_II  = rr_mem[slot_ii];
    assign ks_III    = ks_mem[slot_iii];
    assign mul_VI    = mul_mem[slot_vi];
    assign tl_VII    = tl_mem[slot_vii];
    assign amsen_VII = amsen_mem[slot_vii];
    assign keyon_II  = (csm_cnt != 6'd0) | kon[slot_ii];

    assign cur_op    = cycles[4:3];
    assign zero      = cycles == 5'd0;
    assign half      = cycles[3:0] == 4'd0;
    assign op31_no   = cycles == 5'd31;
    assign m1_enters = cycles[2:0] == 3'd0 && cur_op == 2'd0;
    assign m2_enters = cycles[2:0] == 3'd0 && cur_op == 2'd1;
    assign c1_enters = cycles[2:0] == 3'd0 && cur_op == 2'd2;
    assign c2_enters = cycles[2:0] == 3'd0 && cur_op == 2'd3;

    // NOTE: every flag gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        use_prevprev1  = 1'b0;
        use_internal_x = 1'b0;
        use_internal_y = 1'b0;
        use_prev2      = 1'b0;
        use_prev1      = 1'b0;
        case (cur_op)
            2'd1: begin
                case (con_I)
                    3'd0, 3'd2: use_prevprev1 = 1'b1;
                    3'd1: begin
                        use_prev1     = 1'b1;
                        use_prevprev1 = 1'b1;
                    end
                    3'd5: use_prev1 = 1'b1;
                    default: ;
                endcase
            end
            2'd2: begin
                case (con_I)
                    3'd0, 3'd3, 3'd4, 3'd5, 3'd6: use_prev2 = 1'b1;
                    default: ;
                endcase
            end
            2'd3: begin
                case (con_I)
                    3'd0, 3'd1, 3'd4: use_prev2 = 1'b1;
                    3'd2: begin
                        use_prev2      = 1'b1;
                        use_internal_x = 1'b1;
                    end
                    3'd3: begin
                        use_prev1 = 1'b1;
                        use_prev2 = 1'b1;
                    end
                    3'd5: use_internal_x = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jt51_slot_regbank.sv
// Directed bench for jt51_slot_regbank: expectations are queued as stimulus is
// applied and popped against the DUT outputs one step later.
module tb_jt51_slot_regbank;

    logic       rst, clk, cen;
    logic       up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l;
    logic [1:0] op;
    logic [2:0] ch;
    logic [7:0] op_din;
    logic       up_rl, up_kc, up_kf, up_pms;
    logic [2:0] ch_sel;
    logic [7:0] ch_din;
    logic       up_keyon, csm, overflow_A;
    logic [1:0] rl_I, ams_VII, dt2_I, ks_III;
    logic [2:0] fb_II, con_I, pms_I, dt1_II;
    logic [6:0] kc_I, tl_VII;
    logic [5:0] kf_I;
    logic [3:0] mul_VI, rrate_II, d1l_I;
    logic [4:0] arate_II, rate1_II, rate2_II, cycles;
    logic       amsen_VII, keyon_II;
    logic [1:0] cur_op;
    logic       zero, half, op31_no, op31_acc;
    logic       m1_enters, m2_enters, c1_enters, c2_enters;
    logic       use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;

    jt51_slot_regbank dut (
        .rst(rst), .clk(clk), .cen(cen),
        .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
        .up_dt2(up_dt2), .up_d1l(up_d1l),
        .op(op), .ch(ch), .op_din(op_din),
        .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
        .ch_sel(ch_sel), .ch_din(ch_din),
        .up_keyon(up_keyon), .csm(csm), .overflow_A(overflow_A),
        .rl_I(rl_I), .fb_II(fb_II), .con_I(con_I), .kc_I(kc_I), .kf_I(kf_I),
        .pms_I(pms_I), .ams_VII(ams_VII),
        .dt1_II(dt1_II), .dt2_I(dt2_I), .mul_VI(mul_VI), .tl_VII(tl_VII),
        .ks_III(ks_III), .arate_II(arate_II), .amsen_VII(amsen_VII),
        .rate1_II(rate1_II), .rate2_II(rate2_II), .rrate_II(rrate_II),
        .d1l_I(d1l_I), .keyon_II(keyon_II),
        .cycles(cycles), .cur_op(cur_op), .zero(zero), .half(half),
        .op31_no(op31_no), .op31_acc(op31_acc),
        .m1_enters(m1_enters), .m2_enters(m2_enters),
        .c1_enters(c1_enters), .c2_enters(c2_enters),
        .use_prevprev1(use_prevprev1), .use_internal_x(use_internal_x),
        .use_internal_y(use_internal_y), .use_prev2(use_prev2), .use_prev1(use_prev1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_cyc = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        logic mv;
        mv = cen && !rst;
        @(posedge clk);
        #1;
        if (mv) tb_cyc = (tb_cyc + 1) % 32;
    endtask

    task automatic goto_cyc(input int target);
        for (int i = 0; i < 40 && tb_cyc != target; i++) step();
        expect_v("goto_cycles", 32'(target));
        check(32'(cycles));
    endtask

    task automatic clear_strobes();
        {up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l} = '0;
        {up_rl, up_kc, up_kf, up_pms, up_keyon} = '0;
    endtask

    // which: 0 dt1, 1 tl, 2 ks, 3 amsen, 4 dt2, 5 d1l, 6 keyon
    task automatic wr_op(input int which, input logic [1:0] o, input logic [2:0] c,
                         input logic [7:0] d);
        op = o; ch = c; op_din = d;
        case (which)
            0: up_dt1 = 1'b1;
            1: up_tl = 1'b1;
            2: up_ks = 1'b1;
            3: up_amsen = 1'b1;
            4: up_dt2 = 1'b1;
            5: up_d1l = 1'b1;
            default: up_keyon = 1'b1;
        endcase
        step();
        clear_strobes();
    endtask

    // which: 0 rl/fb/con, 1 kc, 2 kf, 3 pms/ams
    task automatic wr_ch(input int which, input logic [2:0] c, input logic [7:0] d);
        ch_sel = c; ch_din = d;
        case (which)
            0: up_rl = 1'b1;
            1: up_kc = 1'b1;
            2: up_kf = 1'b1;
            default: up_pms = 1'b1;
        endcase
        step();
        clear_strobes();
    endtask

    function automatic logic [31:0] flags();
        return 32'({use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1});
    endfunction

    task automatic keyon_sweep(input string tag, input logic [31:0] mask);
        for (int i = 0; i < 32; i++) begin
            expect_v(tag, 32'(mask[(tb_cyc + 31) % 32]));
            check(32'(keyon_II));
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int zc, hc, ac;
        rst = 1'b1; cen = 1'b0; csm = 1'b0; overflow_A = 1'b0;
        op = '0; ch = '0; op_din = '0; ch_sel = '0; ch_din = '0;
        clear_strobes();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tb_cyc = 0;

        // Reset state
        expect_v("rst_cycles", 32'd0);    check(32'(cycles));
        expect_v("rst_zero", 32'd1);      check(32'(zero));
        expect_v("rst_half", 32'd1);      check(32'(half));
        expect_v("rst_m1_enters", 32'd1); check(32'(m1_enters));
        expect_v("rst_op31_acc", 32'd0);  check(32'(op31_acc));
        expect_v("rst_kc_I", 32'd0);      check(32'(kc_I));
        expect_v("rst_tl_VII", 32'd0);    check(32'(tl_VII));
        expect_v("rst_keyon_II", 32'd0);  check(32'(keyon_II));

        // One full revolution of the slot counter
        cen = 1'b1;
        zc = 0; hc = 0; ac = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            zc += int'(zero);
            hc += int'(half);
            ac += int'(op31_acc);
        end
        expect_v("zero_count", 32'd1);     check(32'(zc));
        expect_v("half_count", 32'd2);     check(32'(hc));
        expect_v("op31_acc_count", 32'd1); check(32'(ac));
        expect_v("wrap_cycles", 32'd0);    check(32'(cycles));

        // Clock enable low freezes the sequencer
        cen = 1'b0;
        repeat (3) step();
        expect_v("cen_hold_cycles", 32'd0); check(32'(cycles));
        cen = 1'b1;

        // Channel key code on channel 3 only
        wr_ch(1, 3'd3, 8'h4A);
        for (int i = 0; i < 32; i++) begin
            expect_v("kc_I_sweep", (tb_cyc % 8 == 3) ? 32'h4A : 32'h0);
            check(32'(kc_I));
            step();
        end

        // Total level on slot 21 seen at stage VII
        wr_op(1, 2'd2, 3'd5, 8'h7F);
        for (int i = 0; i < 32; i++) begin
            expect_v("tl_VII_sweep", (((tb_cyc + 26) % 32) == 21) ? 32'h7F : 32'h0);
            check(32'(tl_VII));
            step();
        end
        wr_op(1, 2'd2, 3'd5, 8'h15);
        goto_cyc(27);
        expect_v("tl_VII_overwrite", 32'h15); check(32'(tl_VII));

        // Write during a read of the same slot: old value until the edge, cen ignored
        cen = 1'b0;
        op = 2'd2; ch = 3'd5; op_din = 8'h33; up_tl = 1'b1;
        #1;
        expect_v("tl_VII_old_during_write", 32'h15); check(32'(tl_VII));
        step();
        clear_strobes();
        expect_v("tl_VII_write_no_cen", 32'h33); check(32'(tl_VII));
        cen = 1'b1;

        // Remaining channel fields
        wr_ch(0, 3'd6, 8'hAE);
        wr_ch(3, 3'd1, 8'h53);
        wr_ch(2, 3'd1, 8'hB7);
        goto_cyc(9);
        expect_v("pms_I", 32'd5);    check(32'(pms_I));
        expect_v("kf_I", 32'h2D);    check(32'(kf_I));
        goto_cyc(14);
        expect_v("rl_I", 32'd2);     check(32'(rl_I));
        expect_v("con_I", 32'd6);    check(32'(con_I));
        expect_v("m2_con6_flags", 32'd0); check(flags());
        goto_cyc(15);
        expect_v("fb_II", 32'd5);    check(32'(fb_II));
        expect_v("ams_VII", 32'd3);  check(32'(ams_VII));

        // Operator fields at their stages
        wr_op(0, 2'd1, 3'd0, 8'h3C);
        wr_op(2, 2'd3, 3'd7, 8'hD5);
        wr_op(3, 2'd0, 3'd2, 8'h9A);
        wr_op(4, 2'd0, 3'd2, 8'h4C);
        wr_op(5, 2'd0, 3'd2, 8'hA7);
        goto_cyc(0);
        expect_v("arate_II", 32'h15); check(32'(arate_II));
        goto_cyc(1);
        expect_v("ks_III", 32'd3);    check(32'(ks_III));
        goto_cyc(2);
        expect_v("dt2_I", 32'd1);     check(32'(dt2_I));
        expect_v("d1l_I", 32'hA);     check(32'(d1l_I));
        goto_cyc(3);
        expect_v("rate1_II", 32'h1A); check(32'(rate1_II));
        expect_v("rate2_II", 32'h0C); check(32'(rate2_II));
        expect_v("rrate_II", 32'd7);  check(32'(rrate_II));
        goto_cyc(8);
        expect_v("amsen_VII", 32'd1); check(32'(amsen_VII));
        expect_v("m2_enters", 32'd1); check(32'(m2_enters));
        expect_v("m1_enters_off", 32'd0); check(32'(m1_enters));
        goto_cyc(9);
        expect_v("dt1_II", 32'd3);    check(32'(dt1_II));
        expect_v("amsen_VII_other", 32'd0); check(32'(amsen_VII));
        goto_cyc(13);
        expect_v("mul_VI", 32'hC);    check(32'(mul_VI));
        goto_cyc(16);
        expect_v("c1_enters", 32'd1); check(32'(c1_enters));
        goto_cyc(24);
        expect_v("c2_enters", 32'd1); check(32'(c2_enters));
        goto_cyc(31);
        expect_v("op31_no", 32'd1);   check(32'(op31_no));
        goto_cyc(0);
        expect_v("op31_acc", 32'd1);  check(32'(op31_acc));

        // Routing flags {prevprev1, internal_x, internal_y, prev2, prev1} on channel 0
        wr_ch(0, 3'd0, 8'h02);
        goto_cyc(8);
        expect_v("m2_con2", 32'b10000);  check(flags());
        goto_cyc(24);
        expect_v("c2_con2", 32'b01010);  check(flags());
        wr_ch(0, 3'd0, 8'h03);
        goto_cyc(24);
        expect_v("c2_con3", 32'b00011);  check(flags());
        wr_ch(0, 3'd0, 8'h05);
        goto_cyc(8);
        expect_v("m2_con5", 32'b00001);  check(flags());
        goto_cyc(16);
        expect_v("c1_con5", 32'b00010);  check(flags());
        goto_cyc(24);
        expect_v("c2_con5", 32'b01000);  check(flags());
        wr_ch(0, 3'd0, 8'h07);
        goto_cyc(24);
        expect_v("c2_con7", 32'b00000);  check(flags());

        // Key-on patterns for channel 3
        wr_op(6, 2'd0, 3'd0, 8'h7B);
        keyon_sweep("keyon_all_ops", 32'h0808_0808);
        wr_op(6, 2'd0, 3'd0, 8'h2B);
        keyon_sweep("keyon_m1_m2", 32'h0000_0808);
        wr_op(6, 2'd0, 3'd0, 8'h03);
        keyon_sweep("keyon_cleared", 32'h0);

        // CSM window
        wr_op(6, 2'd0, 3'd0, 8'h0B);
        csm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_v("csm_no_overflow", 32'((((tb_cyc + 31) % 32) == 3) ? 1 : 0));
            check(32'(keyon_II));
            step();
        end
        overflow_A = 1'b1;
        step();
        csm = 1'b0; overflow_A = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_v("csm_window", 32'd1);
            check(32'(keyon_II));
            step();
        end
        keyon_sweep("after_csm", 32'h0000_0008);

        // Asynchronous reset mid-write and mid-window
        csm = 1'b1; overflow_A = 1'b1;
        step();
        csm = 1'b0; overflow_A = 1'b0;
        op = 2'd2; ch = 3'd5; op_din = 8'h44; up_tl = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        expect_v("async_rst_cycles", 32'd0);   check(32'(cycles));
        expect_v("async_rst_keyon", 32'd0);    check(32'(keyon_II));
        step();
        clear_strobes();
        rst = 1'b0;
        tb_cyc = 0;
        goto_cyc(4);
        expect_v("post_rst_kon", 32'd0);       check(32'(keyon_II));
        goto_cyc(11);
        expect_v("post_rst_kc", 32'd0);        check(32'(kc_I));
        goto_cyc(27);
        expect_v("post_rst_tl", 32'd0);        check(32'(tl_VII));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
